// File: rtl/opr_pkg.sv
// Shared types for the PDP-8 OPR sequencer: step-state encoding, IR bit indices, strobe bundle.
// Pure declarations; no latency and no backpressure.
package opr_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_G1_CLR,
    ST_G1_CMP,
    ST_G1_IAC,
    ST_G1_ROT1,
    ST_G1_ROT2,
    ST_G2_SKIP,
    ST_G2_CLA,
    ST_G2_OSR,
    ST_G3_CLA,
    ST_G3_MQ,
    ST_G3_EAE,
    ST_DONE
  } opr_state_e;

  // IR bit positions, bit 0 = LSB (DEC bit 11); names alias by group.
  localparam int B_IAC = 0;
  localparam int B_BSW = 1;
  localparam int B_HLT = 1;
  localparam int B_RAL = 2;
  localparam int B_OSR = 2;
  localparam int B_RAR = 3;
  localparam int B_TST = 3;
  localparam int B_CML = 4;
  localparam int B_SNL = 4;
  localparam int B_MQL = 4;
  localparam int B_CMA = 5;
  localparam int B_SZA = 5;
  localparam int B_SCA = 5;
  localparam int B_CLL = 6;
  localparam int B_SMA = 6;
  localparam int B_MQA = 6;
  localparam int B_CLA = 7;
  localparam int B_GRP = 8;

  typedef struct packed {
    logic busy;
    logic done;
    logic clr_ac;
    logic clr_l;
    logic cm_ac;
    logic cm_l;
    logic inc_ac;
    logic rot_l;
    logic rot_r;
    logic bsw;
    logic osr_or;
    logic hlt;
    logic skip;
    logic mq_to_ac;
    logic ac_to_mq;
    logic eae_req;
    logic eae_err;
  } opr_strb_t;

  function automatic logic is_opr(input logic [2:0] opcode);
    return opcode == 3'b111;
  endfunction

endpackage

// File: rtl/opr_skip_eval.sv
// Group-2 skip condition: OR of selected AC/L tests, inverted by the sense bit.
// Purely combinational, zero latency; no backpressure.
module opr_skip_eval (
  input  logic i_sma,
  input  logic i_sza,
  input  logic i_snl,
  input  logic i_rev,
  input  logic i_ac_neg,
  input  logic i_ac_zero,
  input  logic i_link,
  output logic o_skip
);

  logic w_cond;

  assign w_cond = (i_sma & i_ac_neg) | (i_sza & i_ac_zero) | (i_snl & i_link);
  assign o_skip = i_rev ? ~w_cond : w_cond;

endmodule

// File: rtl/opr_sequencer.sv
// Sequences one PDP-8 OPR instruction into registered one-cycle datapath strobes.
// G1 done in 6 cycles, G2 in 4, G3 in 3 (+EAE wait); START ignored while busy.
module opr_sequencer
  import opr_pkg::*;
#(
  parameter bit EAE_EN      = 1'b1,
  parameter int EAE_TIMEOUT = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [11:0] IR,
  input  logic        AC_ZERO,
  input  logic        AC_NEG,
  input  logic        LINK,
  input  logic        EAE_ACK,
  output logic        BUSY,
  output logic        DONE,
  output logic        CLR_AC,
  output logic        CLR_L,
  output logic        CM_AC,
  output logic        CM_L,
  output logic        INC_AC,
  output logic        ROT_L,
  output logic        ROT_R,
  output logic        BSW,
  output logic        OSR_OR,
  output logic        HLT,
  output logic        SKIP,
  output logic        MQ_TO_AC,
  output logic        AC_TO_MQ,
  output logic        EAE_REQ,
  output logic        EAE_ERR
);

  localparam int CW = (EAE_TIMEOUT > 0) ? $clog2(EAE_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((EAE_TIMEOUT > 0) ? EAE_TIMEOUT - 1 : 0);

  opr_state_e r_state;
  opr_state_e w_nxt;
  logic [7:0] r_ir;
  logic [7:0] w_ir;
  logic [CW-1:0] r_cnt;
  opr_strb_t r_strb;
  opr_strb_t w_strb;
  logic w_accept;
  logic w_eae_need;
  logic w_expire;
  logic w_skip;
  logic w_rot_l;
  logic w_rot_r;

  assign w_accept   = (r_state == ST_IDLE) && START && is_opr(IR[11:9]);
  // Strobes for the first step are computed from the live IR on the accepting edge.
  assign w_ir       = w_accept ? IR[7:0] : r_ir;
  assign w_eae_need = EAE_EN && ((r_ir[3:1] != 3'b000) || r_ir[B_SCA]);
  assign w_expire   = (EAE_TIMEOUT != 0) && (r_cnt == LAST_CNT);
  assign w_rot_l    = w_ir[B_RAL] & ~w_ir[B_RAR];
  assign w_rot_r    = w_ir[B_RAR] & ~w_ir[B_RAL];

  // Flags are captured on the edge entering the skip step so SKIP can be a registered strobe.
  opr_skip_eval u_skip (
    .i_sma     (w_ir[B_SMA]),
    .i_sza     (w_ir[B_SZA]),
    .i_snl     (w_ir[B_SNL]),
    .i_rev     (w_ir[B_TST]),
    .i_ac_neg  (AC_NEG),
    .i_ac_zero (AC_ZERO),
    .i_link    (LINK),
    .o_skip    (w_skip)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!IR[B_GRP])      w_nxt = ST_G1_CLR;
          else if (!IR[B_IAC]) w_nxt = ST_G2_SKIP;
          else                 w_nxt = ST_G3_CLA;
        end
      end
      ST_G1_CLR:  w_nxt = ST_G1_CMP;
      ST_G1_CMP:  w_nxt = ST_G1_IAC;
      ST_G1_IAC:  w_nxt = ST_G1_ROT1;
      ST_G1_ROT1: w_nxt = ST_G1_ROT2;
      ST_G1_ROT2: w_nxt = ST_DONE;
      ST_G2_SKIP: w_nxt = ST_G2_CLA;
      ST_G2_CLA:  w_nxt = ST_G2_OSR;
      ST_G2_OSR:  w_nxt = ST_DONE;
      ST_G3_CLA:  w_nxt = ST_G3_MQ;
      ST_G3_MQ:   w_nxt = w_eae_need ? ST_G3_EAE : ST_DONE;
      ST_G3_EAE: begin
        if (EAE_ACK || w_expire) w_nxt = ST_DONE;
      end
      ST_DONE:    w_nxt = ST_IDLE;
      default:    w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_strb      = '0;
    w_strb.busy = (w_nxt != ST_IDLE);
    w_strb.done = (w_nxt == ST_DONE);
    case (w_nxt)
      ST_G1_CLR: begin
        w_strb.clr_ac = w_ir[B_CLA];
        w_strb.clr_l  = w_ir[B_CLL];
      end
      ST_G1_CMP: begin
        w_strb.cm_ac = w_ir[B_CMA];
        w_strb.cm_l  = w_ir[B_CML];
      end
      ST_G1_IAC:  w_strb.inc_ac = w_ir[B_IAC];
      ST_G1_ROT1: begin
        w_strb.rot_l = w_rot_l;
        w_strb.rot_r = w_rot_r;
        w_strb.bsw   = w_ir[B_BSW] & ~w_ir[B_RAL] & ~w_ir[B_RAR];
      end
      // Second rotate step turns RAL/RAR into RTL/RTR.
      ST_G1_ROT2: begin
        w_strb.rot_l = w_rot_l & w_ir[B_BSW];
        w_strb.rot_r = w_rot_r & w_ir[B_BSW];
      end
      ST_G2_SKIP: w_strb.skip = w_skip;
      ST_G2_CLA:  w_strb.clr_ac = w_ir[B_CLA];
      ST_G2_OSR: begin
        w_strb.osr_or = w_ir[B_OSR];
        w_strb.hlt    = w_ir[B_HLT];
      end
      ST_G3_CLA:  w_strb.clr_ac = w_ir[B_CLA];
      ST_G3_MQ: begin
        w_strb.mq_to_ac = w_ir[B_MQA];
        w_strb.ac_to_mq = w_ir[B_MQL];
      end
      ST_G3_EAE:  w_strb.eae_req = 1'b1;
      ST_DONE:    w_strb.eae_err = (r_state == ST_G3_EAE) && !EAE_ACK && w_expire;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_ir    <= '0;
      r_strb  <= '0;
    end else begin
      r_state <= w_nxt;
      r_ir    <= w_ir;
      r_strb  <= w_strb;
    end
  end

  // Counts cycles already spent waiting in the EAE step.
  always_ff @(posedge CLK) begin
    if (RESET || (r_state != ST_G3_EAE)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign BUSY     = r_strb.busy;
  assign DONE     = r_strb.done;
  assign CLR_AC   = r_strb.clr_ac;
  assign CLR_L    = r_strb.clr_l;
  assign CM_AC    = r_strb.cm_ac;
  assign CM_L     = r_strb.cm_l;
  assign INC_AC   = r_strb.inc_ac;
  assign ROT_L    = r_strb.rot_l;
  assign ROT_R    = r_strb.rot_r;
  assign BSW      = r_strb.bsw;
  assign OSR_OR   = r_strb.osr_or;
  assign HLT      = r_strb.hlt;
  assign SKIP     = r_strb.skip;
  assign MQ_TO_AC = r_strb.mq_to_ac;
  assign AC_TO_MQ = r_strb.ac_to_mq;
  assign EAE_REQ  = r_strb.eae_req;
  assign EAE_ERR  = r_strb.eae_err;

endmodule
